vblank_sched: RTL and testbench
===============================

# vblank_sched

Frame-synchronous scheduler that shares the vertical-blanking window of the 1024×768@60 (65 MHz) VGA pipeline among up to N game-logic requesters (duck motion, hit detection, score update, sprite loader) needing exclusive access to shared game state. It sits beside `vga_timing` in `top_vga` and consumes its `vblnk`. It serves each pending requester once per frame, one at a time, with a done handshake, a timeout and a forced revoke at end of blanking. It also emits the per-frame tick.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, 4096: maximum grant length in clk cycles before forced revoke.

Ports:
- `clk` input 1: 65 MHz pixel clock (`clk65` at top level).
- `rst` input 1: synchronous, active-high reset.
- `vblnk` input 1: vertical blank from `timing_if` (high during lines 768..805).
- `req` input N_REQ: level request, one bit per requester.
- `done` input N_REQ: one-cycle completion pulse from the granted requester.
- `gnt` output N_REQ: one-hot-or-zero grant.
- `frame_tick` output 1: one-cycle pulse per frame at blanking start.
- `busy` output 1: high while a grant is active.
- `err_timeout` output N_REQ: sticky; requester k was revoked by timeout.
- `err_overrun` output N_REQ: sticky; requester k was revoked by blanking end, or left unserved when blanking ended.

## Operation
- Reset values:
  - All outputs are 0.
  - State is IDLE, `rr_ptr` is 0 and the pending mask is 0.
  - `vblnk_d` resets to 1, so a reset released mid-blank never produces a false rise.
- Rise detect: `rise = vblnk & ~vblnk_d`. Fall detect: `fall = ~vblnk & vblnk_d`.
- FSM states are IDLE, ARB, GRANT and WAIT_END.
  - IDLE → ARB on `rise`. On the same edge: `frame_tick` = 1, pending ← `req`, search start ← `rr_ptr`, `rr_ptr` ← (`rr_ptr` + 1) mod N_REQ.
  - ARB, pending nonzero → GRANT. Select the first set bit searching circularly from the search start. Set its `gnt` bit, clear its pending bit, load the timeout counter with TIMEOUT_CYC−1.
  - ARB, pending zero → WAIT_END.
  - GRANT, `done[k]` for the granted k → ARB. `gnt` is cleared.
  - GRANT, counter reaches 0 without done → ARB. `gnt` is cleared and `err_timeout[k]` is set.
  - WAIT_END → IDLE on `fall`.
- `fall` in any state other than IDLE → IDLE, with the following actions:
  - Clear `gnt`.
  - Set `err_overrun` for the granted bit, if any.
  - Set `err_overrun` for every still-pending bit.
  - Clear the pending mask.
- Precedence when events coincide:
  - `fall` beats `done` and timeout.
  - `done` beats timeout when both occur on the same cycle (no error recorded).
- `done` bits for non-granted requesters are ignored.
- Requests raised after `rise` wait for the next frame. Dropping `req` after `rise` does not cancel the snapshot; the grant is still issued.
- `busy` = |`gnt`.
- The timeout counter is $clog2(TIMEOUT_CYC) bits wide and decrements only in GRANT.

## Timing
- `rise` combinational at cycle t → `frame_tick` and state ARB at t+1 → first `gnt` at t+2.
- `done` at cycle d (`gnt` high) → `gnt` low at d+1 → next `gnt` at d+2. The minimum gap between grants is one cycle.
- `done` is accepted on the first cycle `gnt` is high. The minimum grant length is 1 cycle.
- Timeout: `gnt` is high for exactly TIMEOUT_CYC cycles, then drops on the next edge together with `err_timeout`.
- `fall` at cycle f → `gnt` = 0 and errors set at f+1.
- Blanking is 38×1344 = 51072 cycles. With defaults, 4 timeouts (16384 + ARB cycles) fit with no overrun.
- `rst` asserted at any cycle → all outputs are 0 on the next edge.

## Structure
- `vga_pkg` gains these constants:
  - `VER_BLANK_START` = 768.
  - `VER_TOTAL` = 806.
  - `HOR_TOTAL` = 1344.
  - `VBLANK_CYC` = 51072.
- `vga_pkg` also gains the state typedef `vbs_state_t` {IDLE, ARB, GRANT, WAIT_END}.
- Sub-module `rr_pick`: combinational circular first-one finder. Inputs are the mask and the start index; outputs are a one-hot result and a valid flag. It is unit-testable on its own.
- `top_vga` instantiates `vblank_sched` on `clk65`/`rst` with `vblnk` taken from `timing_if`.

## Test plan
- Reset released mid-blank with `req` = 4'b1111 → no `frame_tick` and no `gnt` until the next blank rise.
- `req` = 4'b0101 at blank rise, done after 10 cycles each → `gnt` 0001 for 10 cycles, 1 idle cycle, then `gnt` 0100. Errors stay 0. `frame_tick` is exactly one pulse at t+1.
- Three consecutive frames with `req` = 4'b1111 and immediate done → first grant goes to bit 0, then bit 1, then bit 2 (rotation).
- Requester 2 never pulses done, TIMEOUT_CYC = 16 → `gnt[2]` high for 16 cycles, then `err_timeout` = 4'b0100, and the next requester is granted 2 cycles later.
- TIMEOUT_CYC = 65536 with `req` = 4'b0011 and no done → at `fall`, `gnt` drops and `err_overrun` = 4'b0011.
- `done[1]` pulsed while `gnt[0]` is held → ignored. `done[0]` coinciding with the last timeout cycle → no `err_timeout`.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants for 1024x768@60 and the vblank scheduler state type.
package vga_pkg;

    localparam int VER_BLANK_START = 768;
    localparam int VER_TOTAL       = 806;
    localparam int HOR_TOTAL       = 1344;
    localparam int VBLANK_CYC      = 51072;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        GRANT,
        WAIT_END
    } vbs_state_t;

endpackage

// File: rtl/rr_pick.sv
// Circular first-one finder: returns the first set bit of mask at or after
// index start, wrapping at N, as a one-hot vector plus a valid flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  onehot,
    output logic          valid
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        onehot = '0;
        valid  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, start} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!valid && mask[idx]) begin
                onehot[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vblank_sched.sv
// Shares the vertical-blanking window among N_REQ requesters: one grant at a
// time, each pending requester served once per frame, with timeout and overrun.
module vblank_sched
    import vga_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vblnk,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic             frame_tick,
    output logic             busy,
    output logic [N_REQ-1:0] err_timeout,
    output logic [N_REQ-1:0] err_overrun,
    output vbs_state_t       dbg_state
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    // Handshake: req is a level sampled once at blanking rise; gnt is one-hot
    // and held until the owner pulses its done bit for one cycle (accepted on
    // any cycle gnt is high, including the first), or until timeout / blank end.
    vbs_state_t       state;
    logic             vblnk_d;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    start;
    logic [N_REQ-1:0] pending;
    logic [CW-1:0]    cnt;
    logic [N_REQ-1:0] pick_oh;
    logic             pick_valid;
    logic             rise;
    logic             fall;

    assign rise      = vblnk & ~vblnk_d;
    assign fall      = ~vblnk & vblnk_d;
    assign busy      = |gnt;
    assign dbg_state = state;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .mask   (pending),
        .start  (start),
        .onehot (pick_oh),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            vblnk_d     <= 1'b1;
            rr_ptr      <= '0;
            start       <= '0;
            pending     <= '0;
            cnt         <= '0;
            gnt         <= '0;
            frame_tick  <= 1'b0;
            err_timeout <= '0;
            err_overrun <= '0;
        end else begin
            vblnk_d    <= vblnk;
            frame_tick <= 1'b0;
            // End of blanking outranks done and timeout in every busy state.
            if (fall && state != IDLE) begin
                gnt         <= '0;
                err_overrun <= err_overrun | gnt | pending;
                pending     <= '0;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            frame_tick <= 1'b1;
                            pending    <= req;
                            start      <= rr_ptr;
                            rr_ptr     <= (rr_ptr == IW'(N_REQ-1)) ? '0 : rr_ptr + 1'b1;
                            state      <= ARB;
                        end
                    end
                    ARB: begin
                        if (pick_valid) begin
                            gnt     <= pick_oh;
                            pending <= pending & ~pick_oh;
                            cnt     <= CW'(TIMEOUT_CYC-1);
                            state   <= GRANT;
                        end else begin
                            state <= WAIT_END;
                        end
                    end
                    GRANT: begin
                        if (|(done & gnt)) begin
                            gnt   <= '0;
                            state <= ARB;
                        end else if (cnt == '0) begin
                            gnt         <= '0;
                            err_timeout <= err_timeout | gnt;
                            state       <= ARB;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    WAIT_END: begin
                        state <= WAIT_END;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vblank_sched.sv
// Randomized bench for vblank_sched: a per-frame grant plan is derived from the
// request snapshot and done latencies, expanded into per-cycle expected outputs.
module tb_vblank_sched;
    import vga_pkg::*;

    localparam int N     = 4;
    localparam int T     = 16;
    localparam int W     = 2 + 3*N;
    localparam int NEVER = 1000;

    logic         clk = 1'b0;
    logic         rst;
    logic         vblnk;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] gnt;
    logic         frame_tick;
    logic         busy;
    logic [N-1:0] err_timeout;
    logic [N-1:0] err_overrun;
    vbs_state_t   dbg_state;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [N-1:0] base_to;
    logic [N-1:0] base_ov;
    int           rr;
    int           lat_cfg[N];
    bit           noise;

    vblank_sched #(.N_REQ(N), .TIMEOUT_CYC(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .vblnk       (vblnk),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .frame_tick  (frame_tick),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (tick,busy,gnt,err_to,err_ov)", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic vb, input logic [N-1:0] r, input logic [N-1:0] d);
        logic [W-1:0] e;
        @(negedge clk);
        e = exp_q.pop_front();
        check(tag, {frame_tick, busy, gnt, err_timeout, err_overrun}, e);
        vblnk = vb;
        req   = r;
        done  = d;
    endtask

    task automatic do_reset(input logic vb, input string tag);
        @(negedge clk);
        rst   = 1'b1;
        vblnk = vb;
        req   = '1;
        done  = '0;
        @(negedge clk);
        check(tag, {frame_tick, busy, gnt, err_timeout, err_overrun}, '0);
        rst     = 1'b0;
        rr      = 0;
        base_to = '0;
        base_ov = '0;
    endtask

    task automatic idle_steps(input int n, input logic vb, input logic [N-1:0] r, input string tag);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({2'b00, {N{1'b0}}, base_to, base_ov});
            step(tag, vb, r, '0);
        end
    endtask

    // One frame: gap low cycles, blank of blen cycles starting at offset 0,
    // then a short low tail so end-of-blank effects are observed.
    task automatic run_frame(input logic [N-1:0] snap, input int blen, input int gap, input string tag);
        int           gk[N];
        int           gs[N];
        int           ge[N];
        bit           gtmo[N];
        int           ng;
        int           s;
        int           k;
        int           lat;
        int           st;
        logic [N-1:0] ovm;
        logic [N-1:0] gexp;
        logic [N-1:0] toe;
        logic [N-1:0] ove;
        logic [N-1:0] plan;
        logic [N-1:0] d;

        for (int g = 0; g < gap; g++) begin
            exp_q.push_back({2'b00, {N{1'b0}}, base_to, base_ov});
            d = noise ? N'($urandom) : '0;
            step(tag, 1'b0, N'($urandom), d);
        end

        ng  = 0;
        s   = 2;
        ovm = '0;
        st  = rr;
        rr  = (rr + 1) % N;
        for (int j = 0; j < N; j++) begin
            k = (st + j) % N;
            if (!snap[k]) continue;
            if (s > blen) begin
                ovm[k] = 1'b1;
                continue;
            end
            lat      = (lat_cfg[k] != 0) ? lat_cfg[k] : int'($urandom_range(1, T + 4));
            gtmo[ng] = (lat > T);
            gk[ng]   = k;
            gs[ng]   = s;
            ge[ng]   = s + (gtmo[ng] ? T : lat) - 1;
            if (ge[ng] >= blen) ovm[k] = 1'b1;
            s = ge[ng] + 2;
            ng++;
        end

        toe = base_to;
        ove = base_ov;
        for (int o = 0; o <= blen + 3; o++) begin
            gexp = '0;
            plan = '0;
            toe  = base_to;
            ove  = base_ov;
            for (int i = 0; i < ng; i++) begin
                if (gs[i] <= o && o <= ge[i] && o <= blen) gexp[gk[i]] = 1'b1;
                if (gtmo[i] && ge[i] < blen && o > ge[i]) toe[gk[i]] = 1'b1;
                if (!gtmo[i] && ge[i] == o) plan[gk[i]] = 1'b1;
            end
            if (o > blen) ove = ove | ovm;
            exp_q.push_back({(o == 1), |gexp, gexp, toe, ove});
            d = noise ? (N'($urandom) & ~gexp) : '0;
            d = d | plan;
            step(tag, (o < blen), (o == 0) ? snap : N'($urandom), d);
        end
        base_to = toe;
        base_ov = ove;
    endtask

    initial begin
        rst   = 1'b1;
        vblnk = 1'b1;
        req   = '0;
        done  = '0;
        noise = 1'b0;
        lat_cfg = '{0, 0, 0, 0};

        do_reset(1'b1, "rst_midblank");
        idle_steps(20, 1'b1, 4'b1111, "midblank_quiet");

        lat_cfg = '{10, 10, 10, 10};
        run_frame(4'b0101, 100, 5, "req0101");

        lat_cfg = '{0, 0, NEVER, 1};
        run_frame(4'b1100, 100, 5, "timeout");

        lat_cfg = '{NEVER, NEVER, NEVER, NEVER};
        run_frame(4'b0011, 10, 5, "overrun");

        noise   = 1'b1;
        lat_cfg = '{T, T, T, T};
        run_frame(4'b0011, 80, 4, "done_last_cycle");

        lat_cfg = '{12, 12, 12, 12};
        run_frame(4'b1111, 100, 3, "ignore_foreign_done");

        lat_cfg = '{0, 0, 0, 0};
        for (int f = 0; f < 20; f++) begin
            run_frame(N'($urandom), int'($urandom_range(8, 120)), int'($urandom_range(1, 6)), "random");
        end

        do_reset(1'b0, "rst_clear");
        idle_steps(3, 1'b0, '0, "post_rst");

        noise   = 1'b0;
        lat_cfg = '{1, 1, 1, 1};
        for (int f = 0; f < 3; f++) begin
            run_frame(4'b1111, 40, 3, "rotate");
        end
        idle_steps(3, 1'b0, '0, "final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
